// File: rtl/rv32_mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory bus between the core's
// data and instruction ports; data has fixed priority with a bounded streak.
module rv32_mem_arbiter #(
    parameter int STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_done,
    output logic [31:0] d_rdata,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STREAK);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  streak;
    logic [31:0] rdata_q;
    logic        take;
    logic        pick_i;

    always_comb begin
        take      = d_req || i_req;
        pick_i    = i_req && (!d_req || streak == STREAK_MAX);
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = BUSY;
            BUSY:    if (mem_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak    <= '0;
            rdata_q   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            grant_id  <= 1'b0;
        end else begin
            if (state == IDLE && take) begin
                grant_id <= pick_i;
                if (pick_i) begin
                    mem_addr  <= i_addr;
                    mem_we    <= 1'b0;
                    mem_wdata <= '0;
                    mem_wstrb <= '0;
                    streak    <= '0;
                end else begin
                    mem_addr  <= d_addr;
                    mem_we    <= d_we;
                    mem_wdata <= d_wdata;
                    mem_wstrb <= d_wstrb;
                    // Streak only grows while fetch is actually waiting.
                    if (!i_req)                    streak <= '0;
                    else if (streak != STREAK_MAX) streak <= streak + 4'd1;
                end
            end
            if (state == BUSY && mem_ack) rdata_q <= mem_rdata;
        end
    end

    assign mem_req = (state == BUSY);
    assign busy    = (state != IDLE);
    assign d_done  = (state == DONE) && !grant_id;
    assign i_done  = (state == DONE) && grant_id;
    assign d_rdata = rdata_q;
    assign i_rdata = rdata_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter with a wait-state memory responder.
module tb_rv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_req, d_we, d_done, i_req, i_done;
    logic [31:0] d_addr, d_wdata, d_rdata, i_addr, i_rdata;
    logic [3:0]  d_wstrb, mem_wstrb;
    logic        mem_req, mem_we, mem_ack, busy, grant_id;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int unsigned mem_wait;
    int unsigned mem_cnt;
    logic [31:0] mem_word;
    logic        force_ack;

    int vectors = 0;
    int miscompares = 0;

    rv32_mem_arbiter #(.STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_done(d_done), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Memory: acks after mem_wait extra cycles of mem_req.
    initial begin
        mem_ack = 1'b0; mem_rdata = '0; mem_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (mem_cnt == mem_wait) begin
                    mem_ack = 1'b1; mem_rdata = mem_word; mem_cnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_cnt = mem_cnt + 1;
                end
            end else begin
                mem_ack = force_ack; mem_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output logic got_i, output int cyc);
        got_i = 1'b0;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (d_done || i_done) begin
                got_i = i_done;
                return;
            end
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    logic got_i;
    int   cyc;
    logic exp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        reset = 1'b1; force_ack = 1'b0;
        d_req = 0; d_addr = '0; d_we = 0; d_wdata = '0; d_wstrb = '0;
        i_req = 0; i_addr = '0; mem_wait = 0; mem_word = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_done", {d_done, i_done}, 0);
        check("rst_grant", grant_id, 0);
        check("rst_rdata", d_rdata, 0);
        reset = 1'b0;

        // Single data read, zero wait
        @(negedge clk);
        d_req = 1; d_addr = 32'h100; d_we = 0; mem_word = 32'hDEADBEEF;
        @(negedge clk);
        check("rd_mem_req_c1", mem_req, 1);
        check("rd_mem_addr", mem_addr, 32'h100);
        check("rd_mem_we", mem_we, 0);
        check("rd_grant", grant_id, 0);
        check("rd_no_done_c1", d_done, 0);
        @(negedge clk);
        check("rd_d_done_c2", d_done, 1);
        check("rd_d_rdata", d_rdata, 32'hDEADBEEF);
        check("rd_i_done", i_done, 0);
        d_req = 0;
        @(negedge clk);
        check("rd_done_pulse", d_done, 0);
        check("rd_idle", busy, 0);

        // Data write, three wait states
        d_req = 1; d_addr = 32'h200; d_we = 1; d_wdata = 32'h12345678;
        d_wstrb = 4'b0011; mem_wait = 3; mem_word = 32'h0BADF00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wr_mem_req", mem_req, 1);
            check("wr_mem_addr", mem_addr, 32'h200);
            check("wr_mem_we", mem_we, 1);
            check("wr_mem_wdata", mem_wdata, 32'h12345678);
            check("wr_mem_wstrb", mem_wstrb, 4'b0011);
            check("wr_no_done", d_done, 0);
        end
        @(negedge clk);
        check("wr_d_done", d_done, 1);
        d_req = 0; d_we = 0;
        @(negedge clk);
        check("wr_done_pulse", d_done, 0);

        // Instruction alone
        i_req = 1; i_addr = 32'h0; mem_wait = 0; mem_word = 32'h00000013;
        @(negedge clk);
        check("if_grant", grant_id, 1);
        check("if_mem_we", mem_we, 0);
        check("if_mem_wstrb", mem_wstrb, 0);
        check("if_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        check("if_i_done", i_done, 1);
        check("if_i_rdata", i_rdata, 32'h00000013);
        check("if_d_done", d_done, 0);
        i_req = 0;
        @(negedge clk);

        // Both held: streak guard lets fetch through every fifth grant
        d_req = 1; d_addr = 32'h400; d_we = 1; d_wstrb = 4'hF; i_req = 1; i_addr = 32'h80;
        for (int n = 0; n < 10; n++) begin
            wait_done(got_i, cyc);
            check("arb_order", got_i, exp_i[n]);
            check("arb_one_done", d_done ^ i_done, 1);
            check("arb_cycles", cyc, (n == 0) ? 2 : 3);
        end
        d_req = 0; i_req = 0; d_we = 0;
        @(negedge clk);

        // Input change mid-flight; request dropped before done
        d_req = 1; d_addr = 32'h100; mem_wait = 2; mem_word = 32'h55AA55AA;
        @(negedge clk);
        check("mf_mem_addr_0", mem_addr, 32'h100);
        d_addr = 32'h300; d_req = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("mf_mem_addr", mem_addr, 32'h100);
            check("mf_mem_req", mem_req, 1);
        end
        @(negedge clk);
        check("mf_d_done", d_done, 1);
        check("mf_rdata", d_rdata, 32'h55AA55AA);
        @(negedge clk);
        check("mf_single_done", d_done, 0);
        check("mf_idle", busy, 0);

        // Spurious ack while idle
        force_ack = 1;
        repeat (2) @(negedge clk);
        check("sp_busy", busy, 0);
        check("sp_done", {d_done, i_done}, 0);
        force_ack = 0;
        @(negedge clk);

        // Reset two cycles before ack
        d_req = 1; d_addr = 32'h600; d_we = 1; d_wdata = 32'hFFFF0000;
        d_wstrb = 4'hC; mem_wait = 3;
        repeat (2) @(negedge clk);
        check("rb_mem_req", mem_req, 1);
        reset = 1; d_req = 0; d_we = 0;
        #1;
        check("rb_mem_req0", mem_req, 0);
        check("rb_busy0", busy, 0);
        check("rb_mem_fields", {mem_addr, mem_wdata} == '0, 1);
        check("rb_mem_ctl", {mem_we, mem_wstrb, grant_id}, 0);
        check("rb_rdata0", d_rdata, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rb_no_done", {d_done, i_done}, 0);
        end
        reset = 0;
        i_req = 1; i_addr = 32'h40; mem_wait = 0; mem_word = 32'hCAFEF00D;
        wait_done(got_i, cyc);
        check("rb_after_i", got_i, 1);
        check("rb_after_cyc", cyc, 2);
        check("rb_after_rdata", i_rdata, 32'hCAFEF00D);
        i_req = 0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
